hamming_decoder: RTL and testbench

HAMMING_DECODER -- requirements
Module: hamming_decoder

---
 rtl/hamming_pkg.sv | 16 +
 rtl/hamming66_correct.sv | 56 +++++
 rtl/hamming_decoder.sv | 93 +++++++++
 tb/tb_hamming_decoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared constants and helpers for the Hamming(66,59) decoder slice.
//   CW_W     : codeword width (positions 1..66)
//   DATA_W   : payload width (CW_W minus parity bits)
//   PARITY_W : parity / syndrome width
//   is_pow2  : true when a Hamming position holds a parity bit
package hamming_pkg;

   localparam int unsigned CW_W     = 66;
   localparam int unsigned DATA_W   = 59;
   localparam int unsigned PARITY_W = 7;

   function automatic logic is_pow2(input int unsigned p);
      return (p != 0) && ((p & (p - 1)) == 0);
   endfunction

endpackage

// File: rtl/hamming66_correct.sv
// Combinational syndrome computation, single-bit correction and payload
// extraction for one codeword.
//   cw        : codeword, index i is Hamming position i+1
//   data      : payload, data[0] is position 3, data[DATA_W-1] the last data position
//   corrected : syndrome in 1..CW_W, that position was flipped
//   uncorr    : syndrome beyond CW_W, payload passed through unmodified
module hamming66_correct #(
   parameter int unsigned CW_W   = hamming_pkg::CW_W,
   parameter int unsigned DATA_W = hamming_pkg::DATA_W
) (
   input  logic [0:CW_W-1]   cw,
   output logic [0:DATA_W-1] data,
   output logic              corrected,
   output logic              uncorr
);

   import hamming_pkg::*;

   logic [PARITY_W-1:0] syn;
   logic [0:CW_W-1]     fixed;

   // XOR-ing each set position number yields, per bit k, the parity of all
   // positions with bit k set.
   always_comb begin
      syn = '0;
      for (int unsigned p = 1; p <= CW_W; p++) begin
         if (cw[p-1]) syn = syn ^ PARITY_W'(p);
      end
   end

   always_comb begin
      corrected = (syn != '0) && (32'(syn) <= CW_W);
      uncorr    = (32'(syn) > CW_W);
   end

   always_comb begin
      fixed = cw;
      for (int unsigned p = 1; p <= CW_W; p++) begin
         fixed[p-1] = cw[p-1] ^ (corrected && (32'(syn) == p));
      end
   end

   // Data bits fill the non-power-of-two positions in ascending order.
   always_comb begin
      int unsigned d;
      data = '0;
      d    = 0;
      for (int unsigned p = 1; p <= CW_W; p++) begin
         if (!is_pow2(p) && (d < DATA_W)) begin
            data[d] = fixed[p-1];
            d++;
         end
      end
   end

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage pipelined Hamming(66,59) decoder with valid/ready handshaking
// and saturating error counters.
//   clk, rst                 : clock, synchronous active-high reset
//   in_data/in_valid/in_ready : received codeword stream
//   out_data/out_valid/out_ready : corrected payload stream
//   out_corrected, out_uncorr : per-frame error flags
//   clr_cnt                  : clears both counters (wins over increment)
//   corr_cnt, uncorr_cnt     : saturating frame counters
module hamming_decoder #(
   parameter int unsigned CW_W   = hamming_pkg::CW_W,
   parameter int unsigned DATA_W = hamming_pkg::DATA_W,
   parameter int unsigned CNT_W  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [0:CW_W-1]    in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [0:DATA_W-1]  out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_corrected,
   output logic               out_uncorr,
   input  logic               clr_cnt,
   output logic [CNT_W-1:0]   corr_cnt,
   output logic [CNT_W-1:0]   uncorr_cnt
);

   import hamming_pkg::*;

   logic              s1_valid;
   logic [0:CW_W-1]   s1_data;
   logic              s2_ready;
   logic              s1_advance;
   logic              out_hs;
   logic [0:DATA_W-1] fix_data;
   logic              fix_corr;
   logic              fix_uncorr;

   assign s2_ready   = !out_valid || out_ready;
   assign s1_advance = s1_valid && s2_ready;
   assign in_ready   = !s1_valid || s1_advance;
   assign out_hs     = out_valid && out_ready;

   // Stage 1: capture the raw codeword.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) s1_data <= in_data;
      end
   end

   hamming66_correct #(
      .CW_W   (CW_W),
      .DATA_W (DATA_W)
   ) u_correct (
      .cw        (s1_data),
      .data      (fix_data),
      .corrected (fix_corr),
      .uncorr    (fix_uncorr)
   );

   // Stage 2: corrected payload and flags; held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_corrected <= 1'b0;
         out_uncorr    <= 1'b0;
      end else if (s2_ready) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data      <= fix_data;
            out_corrected <= fix_corr;
            out_uncorr    <= fix_uncorr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (out_hs) begin
         if (out_corrected && (corr_cnt != '1))  corr_cnt   <= corr_cnt + 1'b1;
         if (out_uncorr && (uncorr_cnt != '1))   uncorr_cnt <= uncorr_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard bench for hamming_decoder: the driver pushes hand-computed
// expectations on each input handshake; the monitor compares every cycle
// the DUT presents an output and pops on the output handshake.
module tb_hamming_decoder;

   localparam int unsigned CW_W   = 66;
   localparam int unsigned DATA_W = 59;
   localparam int unsigned CNT_W  = 16;

   typedef struct {
      logic [0:DATA_W-1] data;
      logic              c;
      logic              u;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst;
   logic [0:CW_W-1]    in_data;
   logic               in_valid;
   logic               in_ready;
   logic [0:DATA_W-1]  out_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_corrected;
   logic               out_uncorr;
   logic               clr_cnt;
   logic [CNT_W-1:0]   corr_cnt;
   logic [CNT_W-1:0]   uncorr_cnt;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   hamming_decoder #(
      .CW_W   (CW_W),
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_corrected (out_corrected),
      .out_uncorr    (out_uncorr),
      .clr_cnt       (clr_cnt),
      .corr_cnt      (corr_cnt),
      .uncorr_cnt    (uncorr_cnt)
   );

   // Codeword with up to four Hamming positions (1-based) set; 0 = unused.
   function automatic logic [0:CW_W-1] mk(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
      logic [0:CW_W-1] v;
      v = '0;
      if (a != 0) v[a-1] = 1'b1;
      if (b != 0) v[b-1] = 1'b1;
      if (c != 0) v[c-1] = 1'b1;
      if (d != 0) v[d-1] = 1'b1;
      return v;
   endfunction

   // Payload with one data index set; negative = all zero.
   function automatic logic [0:DATA_W-1] pd(input int idx);
      logic [0:DATA_W-1] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, req);
      end
   endtask

   // Present one frame; push its expectation once acceptance is certain.
   task automatic send(input logic [0:CW_W-1] cw, input int didx, input logic c, input logic u);
      exp_t e;
      bit   done;
      e.data   = pd(didx);
      e.c      = c;
      e.u      = u;
      in_data  = cw;
      in_valid = 1'b1;
      done     = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL send_timeout in_ready stuck low");
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (sb.size() == 0) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout got %0d pending want 0", sb.size());
      end
      @(negedge clk);
   endtask

   // Monitor: compare whenever output is presented, pop on handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output got data %0h c %0b u %0b want none",
                        out_data, out_corrected, out_uncorr);
            end else begin
               e = sb[0];
               if (out_data !== e.data || out_corrected !== e.c || out_uncorr !== e.u) begin
                  errors++;
                  $display("FAIL frame got data %0h c %0b u %0b want data %0h c %0b u %0b",
                           out_data, out_corrected, out_uncorr, e.data, e.c, e.u);
               end
               if (out_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      clr_cnt   = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_flags", 64'({out_corrected, out_uncorr}), 64'd0);
      check("rst_corr_cnt", 64'(corr_cnt), 64'd0);
      check("rst_uncorr_cnt", 64'(uncorr_cnt), 64'd0);
      @(posedge clk); #1;

      // Directed vectors, full throughput.
      send(mk(0, 0, 0, 0),   -1, 1'b0, 1'b0);  // clean zero
      send(mk(36, 0, 0, 0),  -1, 1'b1, 1'b0);  // syndrome 36
      send(mk(3, 64, 0, 0),   0, 1'b0, 1'b1);  // syndrome 67
      send(mk(1, 2, 3, 0),    0, 1'b0, 1'b0);  // valid codeword, data[0]=1
      send(mk(1, 2, 3, 5),    0, 1'b1, 1'b0);  // data bit 5 flipped back
      send(mk(64, 0, 0, 0),  -1, 1'b1, 1'b0);  // parity-position hit
      send(mk(66, 0, 0, 0),  -1, 1'b1, 1'b0);  // last position, syndrome 66
      send(mk(63, 64, 0, 0), 56, 1'b0, 1'b1);  // syndrome 127, passthrough
      drain();
      check("cnt_corr_directed", 64'(corr_cnt), 64'd4);
      check("cnt_uncorr_directed", 64'(uncorr_cnt), 64'd2);

      // Back-to-back frames with a 4-cycle consumer stall.
      @(posedge clk); #1;
      fork
         begin
            send(mk(36, 0, 0, 0), -1, 1'b1, 1'b0);
            send(mk(1, 2, 3, 0),   0, 1'b0, 1'b0);
            send(mk(3, 64, 0, 0),  0, 1'b0, 1'b1);
         end
         begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
               @(posedge clk); #1;
               if (out_valid) seen = 1'b1;
            end
            if (!seen) begin
               checks++;
               errors++;
               $display("FAIL stall_wait out_valid never rose");
            end
            out_ready = 1'b0;
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check("cnt_corr_stall", 64'(corr_cnt), 64'd5);
      check("cnt_uncorr_stall", 64'(uncorr_cnt), 64'd3);

      // Clear, then saturate the corrected counter.
      @(posedge clk); #1 clr_cnt = 1'b1;
      @(posedge clk); #1 clr_cnt = 1'b0;
      @(negedge clk);
      check("clr_corr_cnt", 64'(corr_cnt), 64'd0);
      check("clr_uncorr_cnt", 64'(uncorr_cnt), 64'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 65535; i++) send(mk(36, 0, 0, 0), -1, 1'b1, 1'b0);
      drain();
      check("corr_cnt_full", 64'(corr_cnt), 64'hFFFF);
      @(posedge clk); #1;
      send(mk(10, 0, 0, 0), -1, 1'b1, 1'b0);
      drain();
      check("corr_cnt_saturated", 64'(corr_cnt), 64'hFFFF);

      // clr_cnt coinciding with a corrected handshake.
      @(posedge clk); #1 out_ready = 1'b0;
      send(mk(20, 0, 0, 0), -1, 1'b1, 1'b0);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 50 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else begin
               @(posedge clk); #1;
            end
         end
         if (!seen) begin
            checks++;
            errors++;
            $display("FAIL clr_wait out_valid never rose");
         end
      end
      out_ready = 1'b1;
      clr_cnt   = 1'b1;
      @(posedge clk); #1 clr_cnt = 1'b0;
      @(negedge clk);
      check("clr_wins_corr_cnt", 64'(corr_cnt), 64'd0);
      @(posedge clk); #1;
      send(mk(36, 0, 0, 0), -1, 1'b1, 1'b0);
      send(mk(3, 64, 0, 0),  0, 1'b0, 1'b1);
      drain();
      check("cnt_corr_pre_rst", 64'(corr_cnt), 64'd1);
      check("cnt_uncorr_pre_rst", 64'(uncorr_cnt), 64'd1);

      // Reset with two frames in flight.
      @(posedge clk); #1 out_ready = 1'b0;
      send(mk(36, 0, 0, 0), -1, 1'b1, 1'b0);
      send(mk(3, 64, 0, 0),  0, 1'b0, 1'b1);
      rst = 1'b1;
      sb.delete();
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("inflight_rst_out_valid", 64'(out_valid), 64'd0);
      check("inflight_rst_in_ready", 64'(in_ready), 64'd1);
      check("inflight_rst_corr_cnt", 64'(corr_cnt), 64'd0);
      check("inflight_rst_uncorr_cnt", 64'(uncorr_cnt), 64'd0);
      @(posedge clk); #1 out_ready = 1'b1;
      send(mk(36, 0, 0, 0), -1, 1'b1, 1'b0);
      drain();
      check("post_rst_corr_cnt", 64'(corr_cnt), 64'd1);
      check("post_rst_uncorr_cnt", 64'(uncorr_cnt), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
